// File: rtl/data_path.sv
// Register-file datapath: 32-bit bus, 16 GPRs, HI/LO/Z/PC/MDR/InPort/Y and a combinational 64-bit ALU.
// Optional DATA_PATH_MULDIV_EN builds signed MUL/DIV; otherwise those opcodes yield zero.
module data_path (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic [4:0]  op,
  input  logic [31:0] Mdatain,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        HIOut,
  input  logic        LOout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCout,
  input  logic        MDRout,
  input  logic        InPortout,
  input  logic        Yout,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighin,
  input  logic        Zlowin,
  input  logic        InPC,
  input  logic        MDRin,
  input  logic        InPortin,
  input  logic        Yin,
  output logic [31:0] BusOut,
  output logic [31:0] mdrData,
  output logic [31:0] BusMuxInR0,  output logic [31:0] BusMuxInR1,
  output logic [31:0] BusMuxInR2,  output logic [31:0] BusMuxInR3,
  output logic [31:0] BusMuxInR4,  output logic [31:0] BusMuxInR5,
  output logic [31:0] BusMuxInR6,  output logic [31:0] BusMuxInR7,
  output logic [31:0] BusMuxInR8,  output logic [31:0] BusMuxInR9,
  output logic [31:0] BusMuxInR10, output logic [31:0] BusMuxInR11,
  output logic [31:0] BusMuxInR12, output logic [31:0] BusMuxInR13,
  output logic [31:0] BusMuxInR14, output logic [31:0] BusMuxInR15,
  output logic [31:0] BusMuxInZhigh,
  output logic [31:0] BusMuxInZlow,
  output logic [31:0] BusMuxInPCout,
  output logic [31:0] BusMuxInInPortout,
  output logic [31:0] BusMuxInYout,
  output logic [31:0] BusMuxInHI,
  output logic [31:0] BusMuxInLO
);

  logic [15:0] r_out, r_in;
  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q, inport_q, y_q;
  logic [31:0] mdr_d;
  logic [63:0] c_d;
  logic [31:0] a, b;
  logic [4:0]  sh;

  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

  // Sources are applied lowest-priority first so the last match (R0out) wins.
  always_comb begin
    BusOut = '0;
    if (Yout)      BusOut = y_q;
    if (InPortout) BusOut = inport_q;
    if (MDRout)    BusOut = mdr_q;
    if (PCout)     BusOut = pc_q;
    if (Zlowout)   BusOut = zlo_q;
    if (Zhighout)  BusOut = zhi_q;
    if (LOout)     BusOut = lo_q;
    if (HIOut)     BusOut = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) BusOut = r_q[i];
    end
  end

  assign a  = y_q;
  assign b  = BusOut;
  assign sh = b[4:0];

`ifdef DATA_PATH_MULDIV_EN
  logic signed [63:0] a_ext, b_ext;
  logic signed [31:0] quo, rem;
  assign a_ext = {{32{a[31]}}, a};
  assign b_ext = {{32{b[31]}}, b};
  assign quo   = (b == '0) ? '0 : $signed(a) / $signed(b);
  assign rem   = (b == '0) ? '0 : $signed(a) % $signed(b);
`endif

  always_comb begin
    c_d = '0;
    case (op)
      5'b00000: c_d = {32'd0, a + b};
      5'b00001: c_d = {32'd0, a - b};
      5'b00010: c_d = {32'd0, a >> sh};
      5'b00011: c_d = {32'd0, a << sh};
      5'b00100: c_d = {32'd0, $signed(a) >>> sh};
      5'b00101: c_d = {32'd0, (a >> sh) | (a << (6'd32 - {1'b0, sh}))};
      5'b00110: c_d = {32'd0, (a << sh) | (a >> (6'd32 - {1'b0, sh}))};
      5'b00111: c_d = {32'd0, a & b};
      5'b01000: c_d = {32'd0, a | b};
      5'b01001: c_d = {32'd0, 32'd0 - b};
      5'b01010: c_d = {32'd0, ~b};
`ifdef DATA_PATH_MULDIV_EN
      5'b01011: c_d = a_ext * b_ext;
      5'b01100: c_d = {rem, quo};
`endif
      default:  c_d = '0;
    endcase
  end

  assign mdr_d = Read ? Mdatain : BusOut;

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zhi_q    <= '0;
      zlo_q    <= '0;
      pc_q     <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
      y_q      <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) r_q[i] <= BusOut;
      end
      if (HIin)     hi_q     <= BusOut;
      if (LOin)     lo_q     <= BusOut;
      if (ZHighin)  zhi_q    <= c_d[63:32];
      if (Zlowin)   zlo_q    <= c_d[31:0];
      if (InPC)     pc_q     <= BusOut;
      if (MDRin)    mdr_q    <= mdr_d;
      if (InPortin) inport_q <= BusOut;
      if (Yin)      y_q      <= BusOut;
    end
  end

  assign mdrData           = mdr_q;
  assign BusMuxInR0        = r_q[0];
  assign BusMuxInR1        = r_q[1];
  assign BusMuxInR2        = r_q[2];
  assign BusMuxInR3        = r_q[3];
  assign BusMuxInR4        = r_q[4];
  assign BusMuxInR5        = r_q[5];
  assign BusMuxInR6        = r_q[6];
  assign BusMuxInR7        = r_q[7];
  assign BusMuxInR8        = r_q[8];
  assign BusMuxInR9        = r_q[9];
  assign BusMuxInR10       = r_q[10];
  assign BusMuxInR11       = r_q[11];
  assign BusMuxInR12       = r_q[12];
  assign BusMuxInR13       = r_q[13];
  assign BusMuxInR14       = r_q[14];
  assign BusMuxInR15       = r_q[15];
  assign BusMuxInZhigh     = zhi_q;
  assign BusMuxInZlow      = zlo_q;
  assign BusMuxInPCout     = pc_q;
  assign BusMuxInInPortout = inport_q;
  assign BusMuxInYout      = y_q;
  assign BusMuxInHI        = hi_q;
  assign BusMuxInLO        = lo_q;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path; expectations follow DATA_PATH_MULDIV_EN when it is defined.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        clear, Read;
  logic [4:0]  op;
  logic [31:0] Mdatain;
  logic [15:0] r_out, r_in;
  logic HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout;
  logic HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin;
  logic [31:0] BusOut, mdrData, bm_zhi, bm_zlo, bm_pc, bm_inport, bm_y, bm_hi, bm_lo;
  logic [31:0] bm_r [16];

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] exp_zhi;

  localparam logic [4:0]  OPS  [13] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                        5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                                        5'b01010, 5'b01111, 5'b11111};
  localparam logic [31:0] OEXP [13] = '{32'h80000037, 32'h7FFFFFEF, 32'h08000001, 32'h00000130,
                                        32'hF8000001, 32'h38000001, 32'h00000138, 32'h00000000,
                                        32'h80000037, 32'hFFFFFFDC, 32'hFFFFFFDB, 32'h00000000,
                                        32'h00000000};

  always #5 Clock = ~Clock;

  data_path dut (
    .Clock(Clock), .clear(clear), .Read(Read), .op(op), .Mdatain(Mdatain),
    .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
    .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
    .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
    .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
    .HIOut(HIOut), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout),
    .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
    .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
    .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
    .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
    .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .InPC(InPC), .MDRin(MDRin), .InPortin(InPortin), .Yin(Yin),
    .BusOut(BusOut), .mdrData(mdrData),
    .BusMuxInR0(bm_r[0]), .BusMuxInR1(bm_r[1]), .BusMuxInR2(bm_r[2]), .BusMuxInR3(bm_r[3]),
    .BusMuxInR4(bm_r[4]), .BusMuxInR5(bm_r[5]), .BusMuxInR6(bm_r[6]), .BusMuxInR7(bm_r[7]),
    .BusMuxInR8(bm_r[8]), .BusMuxInR9(bm_r[9]), .BusMuxInR10(bm_r[10]), .BusMuxInR11(bm_r[11]),
    .BusMuxInR12(bm_r[12]), .BusMuxInR13(bm_r[13]), .BusMuxInR14(bm_r[14]), .BusMuxInR15(bm_r[15]),
    .BusMuxInZhigh(bm_zhi), .BusMuxInZlow(bm_zlo), .BusMuxInPCout(bm_pc),
    .BusMuxInInPortout(bm_inport), .BusMuxInYout(bm_y), .BusMuxInHI(bm_hi), .BusMuxInLO(bm_lo)
  );

  task automatic idle();
    Read = 0; op = '0; r_out = '0; r_in = '0;
    HIOut = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0; InPortout = 0; Yout = 0;
    HIin = 0; LOin = 0; ZHighin = 0; Zlowin = 0; InPC = 0; MDRin = 0; InPortin = 0; Yin = 0;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    idle(); Mdatain = v; Read = 1; MDRin = 1; step(); idle();
  endtask

  task automatic put_r(input int i, input logic [31:0] v);
    load_mdr(v); MDRout = 1; r_in[i] = 1; step(); idle();
  endtask

  task automatic put_y(input logic [31:0] v);
    load_mdr(v); MDRout = 1; Yin = 1; step(); idle();
  endtask

  task automatic alu(input logic [4:0] o, input int src, input logic zl, input logic zh);
    idle(); op = o; r_out[src] = 1; Zlowin = zl; ZHighin = zh; step(); idle();
  endtask

  task automatic test_reset();
    idle(); clear = 0; Mdatain = 32'hA5A5A5A5; Read = 1; MDRin = 1; r_in = '1; Yin = 1; HIin = 1;
    #1;
    total++; if (BusOut !== 32'd0) $display("FAIL reset_bus: got %h expected 0", BusOut); else pass_cnt++;
    step(); step();
    total++; if (mdrData !== 32'd0) $display("FAIL reset_mdr: got %h expected 0", mdrData); else pass_cnt++;
    total++; if (bm_r[3] !== 32'd0 || bm_y !== 32'd0 || bm_hi !== 32'd0)
      $display("FAIL reset_regs: got r3=%h y=%h hi=%h expected 0", bm_r[3], bm_y, bm_hi); else pass_cnt++;
    idle(); clear = 1; step();
  endtask

  task automatic test_bus();
    idle(); #1;
    total++; if (BusOut !== 32'd0) $display("FAIL bus_idle: got %h expected 0", BusOut); else pass_cnt++;
    put_r(5, 32'd3); load_mdr(32'd9);
    r_out[5] = 1; MDRout = 1; #1;
    total++; if (BusOut !== 32'd3) $display("FAIL bus_priority: got %h expected 3", BusOut); else pass_cnt++;
    r_out[5] = 0; #1;
    total++; if (BusOut !== 32'd9) $display("FAIL bus_mdr: got %h expected 9", BusOut); else pass_cnt++;
    idle();
  endtask

  task automatic test_shl();
    load_mdr(32'd12);
    MDRout = 1; r_in[3] = 1; step(); idle();
    r_out[3] = 1; Yin = 1; step(); idle();
    load_mdr(32'd5);
    MDRout = 1; r_in[2] = 1; step(); idle();
    alu(5'b00011, 2, 1, 0);
    total++; if (bm_zlo !== 32'd384) $display("FAIL shl_zlo: got %0d expected 384", bm_zlo); else pass_cnt++;
    Zlowout = 1; r_in[1] = 1; step(); idle();
    total++; if (bm_r[1] !== 32'd384) $display("FAIL shl_r1: got %0d expected 384", bm_r[1]); else pass_cnt++;
  endtask

  task automatic test_mdr_bus_load();
    idle(); Mdatain = 32'h12345678; Read = 0; MDRin = 1; r_out[5] = 1; step(); idle();
    total++; if (mdrData !== 32'd3) $display("FAIL mdr_from_bus: got %h expected 3", mdrData); else pass_cnt++;
  endtask

  task automatic test_special_regs();
    load_mdr(32'h0000_1111);
    MDRout = 1; HIin = 1; LOin = 1; InPC = 1; InPortin = 1; step(); idle();
    total++; if (bm_hi !== 32'h1111 || bm_lo !== 32'h1111 || bm_pc !== 32'h1111 || bm_inport !== 32'h1111)
      $display("FAIL special_load: got hi=%h lo=%h pc=%h in=%h expected 1111", bm_hi, bm_lo, bm_pc, bm_inport);
    else pass_cnt++;
    load_mdr(32'h0000_2222);
    MDRout = 1; LOin = 1; step(); idle();
    total++; if (bm_hi !== 32'h1111 || bm_lo !== 32'h2222)
      $display("FAIL special_hold: got hi=%h lo=%h expected 1111/2222", bm_hi, bm_lo); else pass_cnt++;
    HIOut = 1; LOout = 1; PCout = 1; #1;
    total++; if (BusOut !== 32'h1111) $display("FAIL bus_hi_over_lo: got %h expected 1111", BusOut); else pass_cnt++;
    idle();
  endtask

  task automatic test_alu_ops();
    put_y(32'h80000013); put_r(6, 32'h24);
    total++; if (bm_y !== 32'h80000013) $display("FAIL y_load: got %h expected 80000013", bm_y); else pass_cnt++;
    for (int k = 0; k < 13; k++) begin
      alu(OPS[k], 6, 1, 1);
      total++;
      if (bm_zlo !== OEXP[k] || bm_zhi !== 32'd0)
        $display("FAIL alu_op%b: got zhi=%h zlo=%h expected 0/%h", OPS[k], bm_zhi, bm_zlo, OEXP[k]);
      else pass_cnt++;
      if (k == 10) alu(5'b00000, 6, 1, 1);
    end
  endtask

  task automatic test_mul();
    logic [31:0] e_hi, e_lo;
`ifdef DATA_PATH_MULDIV_EN
    e_hi = 32'd1; e_lo = 32'd0;
`else
    e_hi = 32'd0; e_lo = 32'd0;
`endif
    put_y(32'h10000); put_r(8, 32'h10000);
    alu(5'b00000, 8, 1, 1);
    alu(5'b01011, 8, 1, 1);
    exp_zhi = e_hi;
    total++; if (bm_zhi !== e_hi || bm_zlo !== e_lo)
      $display("FAIL mul: got zhi=%h zlo=%h expected %h/%h", bm_zhi, bm_zlo, e_hi, e_lo); else pass_cnt++;
  endtask

  task automatic test_add();
    put_y(32'd7); put_r(4, 32'hFFFFFFFE);
    alu(5'b00000, 4, 1, 0);
    total++; if (bm_zlo !== 32'd5) $display("FAIL add_zlo: got %h expected 5", bm_zlo); else pass_cnt++;
    total++; if (bm_zhi !== exp_zhi) $display("FAIL add_zhi_hold: got %h expected %h", bm_zhi, exp_zhi); else pass_cnt++;
  endtask

  task automatic test_div();
    logic [31:0] e_hi, e_lo;
`ifdef DATA_PATH_MULDIV_EN
    e_hi = 32'hFFFFFFFF; e_lo = 32'hFFFFFFFD;
`else
    e_hi = 32'd0; e_lo = 32'd0;
`endif
    put_y(32'hFFFFFFF9); put_r(9, 32'd2); put_r(10, 32'd0);
    alu(5'b00000, 9, 1, 1);
    alu(5'b01100, 9, 1, 1);
    total++; if (bm_zhi !== e_hi || bm_zlo !== e_lo)
      $display("FAIL div: got zhi=%h zlo=%h expected %h/%h", bm_zhi, bm_zlo, e_hi, e_lo); else pass_cnt++;
    alu(5'b00000, 9, 1, 1);
    alu(5'b01100, 10, 1, 1);
    total++; if (bm_zhi !== 32'd0 || bm_zlo !== 32'd0)
      $display("FAIL div_by_zero: got zhi=%h zlo=%h expected 0/0", bm_zhi, bm_zlo); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    put_r(7, 32'hDEADBEEF);
    total++; if (bm_r[7] !== 32'hDEADBEEF) $display("FAIL r7_load: got %h expected deadbeef", bm_r[7]); else pass_cnt++;
    r_out[5] = 1; r_in[7] = 1; #2;
    clear = 0; #1;
    total++; if (bm_r[7] !== 32'd0 || BusOut !== 32'd0)
      $display("FAIL reset_async: got r7=%h bus=%h expected 0", bm_r[7], BusOut); else pass_cnt++;
    step();
    total++; if (bm_r[7] !== 32'd0 || bm_r[5] !== 32'd0)
      $display("FAIL reset_ignore_load: got r7=%h r5=%h expected 0", bm_r[7], bm_r[5]); else pass_cnt++;
    idle(); clear = 1;
    put_r(7, 32'h55);
    total++; if (bm_r[7] !== 32'h55) $display("FAIL reset_resume: got %h expected 55", bm_r[7]); else pass_cnt++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_zhi = '0;
    Mdatain = '0;
    idle();
    clear = 0;
    test_reset();
    test_bus();
    test_shl();
    test_mdr_bus_load();
    test_special_regs();
    test_alu_ops();
    test_mul();
    test_add();
    test_div();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Clock  input  1  rising-edge clock for all registers.
REQ-003 clear  input  1  asynchronous active-low reset.
REQ-004 Read  input  1  MDR source select: 1 = Mdatain, 0 = BusOut.
REQ-005 op  input  5  ALU operation select.
REQ-006 Mdatain  input  32  memory data into MDR.
REQ-007 R0out..R15out, HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout  input  1 each  bus-drive selects.
REQ-008 R0in..R15in, HIin, LOin, ZHighin, Zlowin, InPC, MDRin, InPortin, Yin  input  1 each  register load enables; InPC is the PC load enable.
REQ-009 BusOut  output  32  current bus value.
REQ-010 mdrData  output  32  MDR contents.
REQ-011 BusMuxInR0..BusMuxInR15, BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout, BusMuxInInPortout, BusMuxInYout, BusMuxInHI, BusMuxInLO  output  32 each  contents of the named registers.
REQ-012 Port order SHALL be: Clock, clear, Read, op, Mdatain, then the out-selects, in-enables and outputs in the order listed in REQ-007 to REQ-011.

Function
REQ-013 Registers: R0-R15, HI, LO, ZHI, ZLO, PC, MDR, InPort, Y; all 32-bit.
REQ-014 BusOut SHALL be combinational and selected by a fixed priority: R0out..R15out, HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout (first listed wins).
REQ-015 With no select asserted, BusOut SHALL be 0.
REQ-016 On a rising edge with its enable high, R0-R15, HI, LO, PC, InPort and Y SHALL load BusOut; a disabled register SHALL hold its value.
REQ-017 On a rising edge with MDRin high, MDR SHALL load Mdatain when Read=1 and BusOut when Read=0.
REQ-018 The ALU SHALL be combinational with A=Y, B=BusOut, and SHALL produce a 64-bit result C.
REQ-019 Zlowin SHALL load C[31:0] into ZLO; ZHighin SHALL load C[63:32] into ZHI; both SHALL take effect on the same edge when asserted together.
REQ-020 op encoding (result in C[31:0], C[63:32]=0 unless stated):
- 00000 ADD, A+B mod 2^32
- 00001 SUB, A-B
- 00010 SHR, logical right shift
- 00011 SHL, A<<B[4:0]
- 00100 SHRA, arithmetic right shift
- 00101 ROR
- 00110 ROL
- 00111 AND
- 01000 OR
- 01001 NEG, -B
- 01010 NOT, ~B
- 01011 MUL, signed A*B, full 64 bits
- 01100 DIV, signed; C[31:0]=quotient, C[63:32]=remainder
- all other codes C=0
REQ-021 Shift and rotate amounts SHALL use B[4:0] only.
REQ-022 DIV with B=0 SHALL give C=0.
REQ-023 Every load SHALL complete in one cycle: a value is visible on BusMuxIn*/mdrData after the loading edge.

Reset
REQ-024 While clear=0, all registers SHALL be 0 immediately, independent of Clock.
REQ-025 While clear=0, load enables SHALL be ignored.
REQ-026 Reset asserted mid-operation SHALL discard any pending load; normal operation SHALL resume on the first rising edge after clear returns high.

Configuration
REQ-027 Macro DATA_PATH_MULDIV_EN: when defined, MUL and DIV SHALL behave as in REQ-020; when undefined, opcodes 01011 and 01100 SHALL give C=0 and no multiplier/divider logic SHALL be built.

Verification
REQ-028 SHL: Mdatain=12, Read+MDRin, then MDRout+R3in, then R3out+Yin; Mdatain=5 into MDR, then MDRout+R2in; op=00011 with R2out+Zlowin, then Zlowout+R1in -> ZLO=384, R1=384.
REQ-029 ADD: Y=7, bus=R4=0xFFFFFFFE, op=00000, Zlowin -> ZLO=5, ZHI unchanged.
REQ-030 MUL (macro defined): Y=0x10000, bus=0x10000, op=01011, Zlowin+ZHighin -> ZHI=1, ZLO=0; with the macro undefined -> both 0.
REQ-031 Bus: no select asserted -> BusOut=0; R5out and MDRout asserted together with R5=3 and MDR=9 -> BusOut=3.
REQ-032 Reset: load R7=0xDEADBEEF, pulse clear=0 between edges -> BusMuxInR7=0 immediately, and a concurrent R7in has no effect.
REQ-033 DIV: Y=-7, bus=2, op=01100 -> ZLO=-3 (0xFFFFFFFD), ZHI=-1; bus=0 -> ZLO=ZHI=0.
